// File: rtl/organ_pkg.sv
// Shared constants, state type and note decode for the organ key-input path.
package organ_pkg;

  localparam logic [2:0] KEY_NONE = 3'd7;

  localparam logic [1:0] TONE_LOW  = 2'b10;
  localparam logic [1:0] TONE_MID  = 2'b01;
  localparam logic [1:0] TONE_HIGH = 2'b11;
  localparam logic [1:0] TONE_OFF  = 2'b00;

  // Key-matrix indices (col*4 + row) of the tone-select keys.
  localparam int unsigned KEY_TONE_LOW  = 8;
  localparam int unsigned KEY_TONE_MID  = 9;
  localparam int unsigned KEY_TONE_HIGH = 10;
  localparam int unsigned KEY_TONE_OFF  = 11;

  localparam int unsigned NUM_NOTES = 7;

  typedef enum logic {IDLE, HELD} key_state_e;

  // Lowest-index pressed note among keys 0..6, or KEY_NONE.
  function automatic logic [2:0] note_decode(input logic [15:0] keys);
    logic [2:0] code;
    code = KEY_NONE;
    for (int i = int'(NUM_NOTES) - 1; i >= 0; i--) begin
      if (keys[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-snapshot debouncer: a raw scan is accepted only after DEBOUNCE_SCANS
// consecutive identical scans, so the stable vector never changes piecemeal.
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [15:0] raw_vec,
  input  logic        scan_done,
  output logic [15:0] stable_vec,
  output logic        stable_upd
);
  import organ_pkg::*;

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);

  logic [15:0]     prev_q, prev_d;
  logic [15:0]     stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            upd_q, upd_d;

  // Match counting and stable-vector load on each completed scan.
  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd_d    = 1'b0;
    if (scan_done) begin
      prev_d = raw_vec;
      if (raw_vec != prev_q) begin
        cnt_d = CntW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CntMax) begin
        stable_d = raw_vec;
        upd_d    = 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      upd_q    <= upd_d;
    end
  end

  assign stable_vec = stable_q;
  assign stable_upd = upd_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low key-matrix scanner: column drive, row synchroniser, snapshot
// assembly, debounce, note/tone decode and press/release strobes.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [3:0] key_row_n,
  output logic [3:0] key_col_n,
  output logic [2:0] key_code,
  output logic [1:0] tone,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);
  import organ_pkg::*;

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_q, col_d;
  logic [15:0]     raw_q, raw_d;
  logic            slot_end, scan_done;

  logic [15:0]     stable_vec;
  logic            stable_upd;

  key_state_e      state_q, state_d;
  logic [2:0]      key_code_q, key_code_d;
  logic [1:0]      tone_q, tone_d;
  logic            key_valid_q;
  logic            press_q, press_d;
  logic            release_q, release_d;

  logic [2:0]      note_cand;
  logic [1:0]      tone_cand;
  logic            tone_hit;

  // Keys 7 and 12..15 carry no function.
  logic unused_keys;
  assign unused_keys = ^{stable_vec[15:12], stable_vec[7]};

  assign slot_end  = (div_q == DivLast);
  assign scan_done = slot_end && (col_q == 2'd3);
  assign key_col_n = ~(4'b0001 << col_q);

  // Column slot timing and snapshot assembly; rows sampled at the end of each slot.
  always_comb begin
    div_d = slot_end ? '0 : div_q + 1'b1;
    col_d = slot_end ? col_q + 2'd1 : col_q;
    raw_d = raw_q;
    if (slot_end) raw_d[{col_q, 2'b00} +: 4] = ~row_s2_q;
  end

  // Synchroniser, scan counters and raw snapshot.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      col_q    <= '0;
      raw_q    <= '0;
    end else begin
      row_s1_q <= key_row_n;
      row_s2_q <= row_s1_q;
      div_q    <= div_d;
      col_q    <= col_d;
      raw_q    <= raw_d;
    end
  end

  // The debouncer sees the vector including this cycle's column-3 sample.
  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .sysclk    (sysclk),
    .rst       (rst),
    .raw_vec   (raw_d),
    .scan_done (scan_done),
    .stable_vec(stable_vec),
    .stable_upd(stable_upd)
  );

  // Tone candidate: lowest-index pressed tone key wins.
  always_comb begin
    tone_hit  = 1'b1;
    tone_cand = TONE_OFF;
    if (stable_vec[KEY_TONE_LOW]) begin
      tone_cand = TONE_LOW;
    end else if (stable_vec[KEY_TONE_MID]) begin
      tone_cand = TONE_MID;
    end else if (stable_vec[KEY_TONE_HIGH]) begin
      tone_cand = TONE_HIGH;
    end else if (stable_vec[KEY_TONE_OFF]) begin
      tone_cand = TONE_OFF;
    end else begin
      tone_hit = 1'b0;
    end
  end

  assign note_cand = note_decode(stable_vec);

  // Note FSM and tone latch, advanced only on stable updates.
  always_comb begin
    state_d    = state_q;
    key_code_d = key_code_q;
    tone_d     = tone_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    if (stable_upd) begin
      if (tone_hit) tone_d = tone_cand;
      case (state_q)
        IDLE: begin
          if (note_cand != KEY_NONE) begin
            state_d    = HELD;
            key_code_d = note_cand;
            press_d    = 1'b1;
          end
        end
        HELD: begin
          if (note_cand == KEY_NONE) begin
            state_d    = IDLE;
            key_code_d = KEY_NONE;
            release_d  = 1'b1;
          end else if (note_cand != key_code_q) begin
            // Roll-over to another note: new press, no release.
            key_code_d = note_cand;
            press_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_code_q  <= KEY_NONE;
      tone_q      <= TONE_OFF;
      key_valid_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      tone_q      <= tone_d;
      key_valid_q <= (key_code_d != KEY_NONE);
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign key_code    = key_code_q;
  assign tone        = tone_q;
  assign key_valid   = key_valid_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: board key-matrix model, hand sequences for latency,
// bounce and reset, a table of key patterns, and random patterns checked
// against a settle-level model of note/tone/strobe behaviour.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_SCANS = 3;
  localparam int          HOLD           = 100;
  localparam int          LAT            = 67;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b0;
  logic [3:0] key_row_n;
  logic [3:0] key_col_n;
  logic [2:0] key_code;
  logic [1:0] tone;
  logic       key_valid, key_press, key_release;

  logic [15:0] keys = '0;

  int checks    = 0;
  int failures  = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;
  int both_cnt  = 0;
  int valid_bad = 0;

  int m_code = 7;
  int m_tone = 0;

  typedef struct {
    logic [15:0] k;
    int          code;
    int          tn;
    int          p;
    int          r;
  } vec_t;

  vec_t tbl [14];

  always #5 sysclk = ~sysclk;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .key_row_n  (key_row_n),
    .key_col_n  (key_col_n),
    .key_code   (key_code),
    .tone       (tone),
    .key_valid  (key_valid),
    .key_press  (key_press),
    .key_release(key_release)
  );

  // Board matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    key_row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!key_col_n[c] && keys[c*4 + r]) key_row_n[r] = 1'b0;
      end
    end
  end

  // Strobe monitor.
  always @(negedge sysclk) begin
    if (key_press) press_cnt <= press_cnt + 1;
    if (key_release) rel_cnt <= rel_cnt + 1;
    if (key_press && key_release) both_cnt <= both_cnt + 1;
    if (key_valid != (key_code != 3'd7)) valid_bad <= valid_bad + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_note(input logic [15:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i;
    return 7;
  endfunction

  function automatic int ref_tone(input logic [15:0] k, input int cur);
    if (k[8]) return 2;
    if (k[9]) return 1;
    if (k[10]) return 3;
    if (k[11]) return 0;
    return cur;
  endfunction

  // Settled effect of moving from the model's current state to pattern k.
  task automatic apply_model(input logic [15:0] k, output int ec, output int et,
                             output int ep, output int er);
    int n;
    n  = ref_note(k);
    ep = (n != 7 && n != m_code) ? 1 : 0;
    er = (n == 7 && m_code != 7) ? 1 : 0;
    m_code = n;
    m_tone = ref_tone(k, m_tone);
    ec = m_code;
    et = m_tone;
  endtask

  task automatic hold_and_check(input string name, input logic [15:0] k, input int ec,
                                input int et, input int ep, input int er);
    int p0, r0;
    @(negedge sysclk);
    keys = k;
    p0 = press_cnt;
    r0 = rel_cnt;
    repeat (HOLD) @(negedge sysclk);
    check({name, ".code"}, int'(key_code), ec);
    check({name, ".tone"}, int'(tone), et);
    check({name, ".valid"}, int'(key_valid), (ec != 7) ? 1 : 0);
    check({name, ".press"}, press_cnt - p0, ep);
    check({name, ".release"}, rel_cnt - r0, er);
  endtask

  initial begin
    int p0, r0, found, code_at;
    int ec, et, ep, er;
    logic [15:0] rk;

    tbl[0]  = '{16'h0000, 7, 0, 0, 1};
    tbl[1]  = '{16'h0028, 3, 0, 1, 0};
    tbl[2]  = '{16'h0020, 5, 0, 1, 0};
    tbl[3]  = '{16'h0000, 7, 0, 0, 1};
    tbl[4]  = '{16'h0400, 7, 3, 0, 0};
    tbl[5]  = '{16'h0000, 7, 3, 0, 0};
    tbl[6]  = '{16'h0300, 7, 2, 0, 0};
    tbl[7]  = '{16'h0800, 7, 0, 0, 0};
    tbl[8]  = '{16'h0200, 7, 1, 0, 0};
    tbl[9]  = '{16'h9080, 7, 1, 0, 0};
    tbl[10] = '{16'h0402, 1, 3, 1, 0};
    tbl[11] = '{16'h0042, 1, 3, 0, 0};
    tbl[12] = '{16'h2001, 0, 3, 1, 0};
    tbl[13] = '{16'h0000, 7, 3, 0, 1};

    // Power-on reset.
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst.col", int'(key_col_n), 4'b1110);
    check("rst.code", int'(key_code), 7);
    check("rst.tone", int'(tone), 0);
    check("rst.valid", int'(key_valid), 0);
    check("rst.press", int'(key_press), 0);
    check("rst.release", int'(key_release), 0);
    rst = 1'b0;
    repeat (HOLD) @(negedge sysclk);

    // Clean press of key 2 within the latency bound.
    @(negedge sysclk);
    keys = 16'h0004;
    apply_model(keys, ec, et, ep, er);
    p0 = press_cnt;
    found = 0;
    code_at = 0;
    for (int i = 0; i < LAT && found == 0; i++) begin
      @(negedge sysclk);
      if (key_press) begin
        found = 1;
        code_at = int'(key_code);
      end
    end
    check("press_latency.hit", found, 1);
    check("press_latency.code", code_at, 2);
    repeat (HOLD) @(negedge sysclk);
    check("press_latency.once", press_cnt - p0, 1);
    check("press_latency.valid", int'(key_valid), 1);

    // Clean release.
    keys = 16'h0000;
    apply_model(keys, ec, et, ep, er);
    r0 = rel_cnt;
    p0 = press_cnt;
    found = 0;
    for (int i = 0; i < LAT && found == 0; i++) begin
      @(negedge sysclk);
      if (key_release) found = 1;
    end
    check("release_latency.hit", found, 1);
    repeat (HOLD) @(negedge sysclk);
    check("release_latency.code", int'(key_code), 7);
    check("release_latency.once", rel_cnt - r0, 1);
    check("release_latency.nopress", press_cnt - p0, 0);

    // Key 4 bouncing every 5 cycles never reaches three matching scans.
    p0 = press_cnt;
    r0 = rel_cnt;
    for (int i = 0; i < 40; i++) begin
      keys[4] = ~keys[4];
      repeat (5) @(negedge sysclk);
    end
    check("bounce.press", press_cnt - p0, 0);
    check("bounce.release", rel_cnt - r0, 0);
    apply_model(16'h0010, ec, et, ep, er);
    hold_and_check("bounce_hold", 16'h0010, ec, et, ep, er);

    // Table of directed patterns; model tracks along for the random phase.
    for (int i = 0; i < 14; i++) begin
      apply_model(tbl[i].k, ec, et, ep, er);
      hold_and_check($sformatf("vec%0d", i), tbl[i].k, tbl[i].code, tbl[i].tn, tbl[i].p,
                     tbl[i].r);
    end

    // Random sparse key patterns against the model.
    for (int i = 0; i < 24; i++) begin
      rk = 16'($urandom & $urandom);
      apply_model(rk, ec, et, ep, er);
      hold_and_check($sformatf("rand%0d", i), rk, ec, et, ep, er);
    end

    // Reset mid-scan with a note and tone active.
    apply_model(16'h0204, ec, et, ep, er);
    hold_and_check("pre_reset", 16'h0204, ec, et, ep, er);
    @(negedge sysclk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.code", int'(key_code), 7);
    check("midrst.tone", int'(tone), 0);
    check("midrst.valid", int'(key_valid), 0);
    check("midrst.press", int'(key_press), 0);
    check("midrst.release", int'(key_release), 0);
    check("midrst.col", int'(key_col_n), 4'b1110);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    #1;
    check("post_rst.col0", int'(key_col_n), 4'b1110);
    @(negedge sysclk);
    @(negedge sysclk);
    @(negedge sysclk);
    check("post_rst.col0_end", int'(key_col_n), 4'b1110);
    @(negedge sysclk);
    check("post_rst.col1", int'(key_col_n), 4'b1101);
    m_code = 7;
    m_tone = 0;
    apply_model(16'h0204, ec, et, ep, er);
    hold_and_check("post_reset", 16'h0204, ec, et, ep, er);

    check("strobe_overlap", both_cnt, 0);
    check("valid_tracks_code", valid_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Input-side counterpart of the organ's LED-matrix display driver. Scans a 4×4 active-low key matrix, debounces it, and produces the signals the display driver consumes:
- a 3-bit note code, where 7 means no note held;
- a 2-bit tone/colour select.

It also emits one-cycle press and release strobes for the tone generator. The block sits between the board key matrix pins and the display and tone logic, all in the `sysclk` domain.

## Interface
Parameters:
- `SCAN_DIV`, 4: `sysclk` cycles each column is driven. Legal range is 4 or more.
- `DEBOUNCE_SCANS`, 3: consecutive identical full scans needed before a snapshot is accepted. Legal range is 1 or more.

Ports:
- `sysclk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key_row_n` in 4: matrix row inputs, pulled up; low means a key in the driven column is closed.
- `key_col_n` out 4: column drive, one-cold; bit *c* low means column *c* is driven.
- `key_code` out 3: held note 0..6 (Do..Si); 7 means none.
- `tone` out 2: colour select. 2'b10 is low/red, 2'b01 is mid/green, 2'b11 is high/orange, 2'b00 is off.
- `key_valid` out 1: high while `key_code` is not 7.
- `key_press` out 1: one-cycle pulse when a new note is accepted.
- `key_release` out 1: one-cycle pulse when `key_code` returns to 7.

## Operation
- **Key index:** key index = col*4 + row.
- **Note keys:** keys 0..6 are notes.
- **Tone keys:**
  - key 8 selects `tone`=2'b10.
  - key 9 selects 2'b01.
  - key 10 selects 2'b11.
  - key 11 selects 2'b00.
- **Ignored keys:** keys 7 and 12..15 are ignored.
- **Column scan:** a column counter runs 0→3→0. Each column is held for `SCAN_DIV` cycles. `key_col_n` = ~(1<<col).
- **Row synchronisation:** `key_row_n` passes through a 2-flop synchroniser.
- **Row sampling:** the synchronised rows are sampled on the last cycle of each column slot. This gives 2 or more cycles of settle time beyond the synchroniser.
- **Snapshot build:** samples are assembled into a 16-bit raw vector, active-high. The vector is complete at the end of column 3.
- **Debounce:** the raw vector is compared with the previous raw vector.
  - If equal, a match counter increments, saturating at `DEBOUNCE_SCANS`.
  - If different, the counter is reset to 1.
  - When the counter reaches `DEBOUNCE_SCANS`, the raw vector is loaded into the stable vector.
- **Note decode:** the lowest-index pressed note among 0..6 in the stable vector wins. If none is pressed, the candidate is 7.
- **Tone decode:** the lowest-index pressed tone key among 8..11 sets `tone`. `tone` holds its value after the key is released. No tone key pressed means no change.
- **State machine, evaluated on each stable update:**
  - IDLE: candidate ≠7 → HELD. Load `key_code` and pulse `key_press`.
  - HELD: candidate = 7 → IDLE. Set `key_code`=7 and pulse `key_release`.
  - HELD: candidate ≠ `key_code` and ≠7 → stay in HELD. Load the new code and pulse `key_press` only; no release pulse.
  - HELD: candidate = `key_code` → no action.
- **Simultaneous note and tone change** in one stable update: both take effect in the same cycle.

## Timing
- **Reset values:**
  - `key_col_n`=4'b1110
  - `key_code`=3'd7
  - `tone`=2'b00
  - `key_valid`=0, `key_press`=0, `key_release`=0
  - counters, previous vector and stable vector all zero
  - state IDLE
- **Scan period:** 4×`SCAN_DIV` cycles, which is 16 with the defaults.
- **Press latency:** from a stable pin change to the `key_press` pulse is at most (`DEBOUNCE_SCANS`+1) scans + 3 cycles, which is 67 cycles with the defaults.
- **Output timing:** `key_code` and `tone` update on the same edge as the strobe. `key_valid` is registered equal to (`key_code` ≠7).
- **Bounce rejection:** a glitch shorter than one scan, or one that alters any single scan, restarts the debounce. The stable vector is never partially updated.
- **Reset mid-scan:** all state is cleared immediately and scanning restarts at column 0 after release.
- **Strobes:** `key_press` and `key_release` are never high in the same cycle.

## Structure
- Package `organ_pkg` holds:
  - `KEY_NONE`=3'd7
  - tone encodings `TONE_LOW`, `TONE_MID`, `TONE_HIGH`, `TONE_OFF`
  - key-map index constants for tone keys 8..11
  - state enum {IDLE, HELD}
- Sub-module `keypad_debounce`, parameterised by `DEBOUNCE_SCANS`:
  - inputs: raw 16-bit vector and a scan-done strobe
  - outputs: stable vector and a stable-update strobe
- The top level holds the column scanner, synchroniser, decode and FSM.

## Test plan
- **Reset:** assert `rst` mid-scan → all outputs at reset values within the same cycle; `key_col_n`=4'b1110 after release.
- **Clean press:** hold key 2 (col 0, row 2) steady → one `key_press` with `key_code`=2 and `key_valid`=1 within 67 cycles. Release → one `key_release` and `key_code`=7.
- **Bounce:** toggle key 4 every 5 cycles for 200 cycles, then hold → no strobe during bouncing; exactly one `key_press` with `key_code`=4 after the hold.
- **Priority and roll-over:** hold keys 5 and 3 → `key_code`=3. Release key 3 while key 5 stays held → `key_press` with `key_code`=5 and no `key_release`.
- **Tone:**
  - press key 10 → `tone`=2'b11, held after release, `key_code` stays 7.
  - press keys 8 and 9 together → `tone`=2'b10.
  - press key 11 → `tone`=2'b00.
- **Ignored keys:** press keys 7, 12 and 15 → no strobes, `key_code`=7, `tone` unchanged.
